// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, block constants and the
// byte-level round transforms used by the full and final round datapaths.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_BLK_W  = 128;
    localparam int AES_KIDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [AES_BLK_W-1:0] sub_bytes(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Byte i of the block sits in row i%4, column i/4 (column-major, byte 0 on top).
    function automatic logic [AES_BLK_W-1:0] shift_rows(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES encryption round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
module aes_final_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    output logic [AES_BLK_W-1:0] state_out
);

    assign state_out = shift_rows(sub_bytes(state_in)) ^ round_key;

endmodule

// File: rtl/encrypt_round.sv
// One full AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encrypt_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    output logic [AES_BLK_W-1:0] state_out
);

    assign state_out = mix_columns(shift_rows(sub_bytes(state_in))) ^ round_key;

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller, one round per clock, external key schedule.
// Optional macro AES_ENC_CTRL_ABORT_EN adds an abort input that drops the block in flight.
module aes128_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int KIDX_W = AES_KIDX_W
)
(
    input  logic                 clk,
    input  logic                 reset,
`ifdef AES_ENC_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    output logic [KIDX_W-1:0]    key_idx,
    input  logic [AES_BLK_W-1:0] round_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic                 busy
);

    aes_state_e           state, state_nxt;
    logic [3:0]           rc, rc_nxt;
    logic [AES_BLK_W-1:0] state_reg, data_nxt;
    logic [AES_BLK_W-1:0] round_out, final_out;

    encrypt_round u_round (
        .state_in  (state_reg),
        .round_key (round_key),
        .state_out (round_out)
    );

    aes_final_round u_final (
        .state_in  (state_reg),
        .round_key (round_key),
        .state_out (final_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rc        <= '0;
            state_reg <= '0;
        end else begin
            state     <= state_nxt;
            rc        <= rc_nxt;
            state_reg <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        data_nxt  = state_reg;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        key_idx   = '0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    data_nxt  = plaintext ^ round_key;
                    rc_nxt    = 4'd1;
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                key_idx  = KIDX_W'(rc);
                data_nxt = round_out;
                rc_nxt   = rc + 4'd1;
                if (rc == 4'(NR - 1)) begin
                    state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                key_idx   = KIDX_W'(NR);
                data_nxt  = final_out;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rc_nxt    = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                rc_nxt    = '0;
                data_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef AES_ENC_CTRL_ABORT_EN
        if (abort && (state != ST_IDLE)) begin
            rc_nxt    = '0;
            data_nxt  = '0;
            state_nxt = ST_IDLE;
        end
`endif
    end

    // Ciphertext is masked so the bus never leaks intermediate round state.
    assign ciphertext = out_valid ? state_reg : '0;

endmodule

// File: doc/aes128_enc_ctrl.md
AES128_ENC_CTRL -- requirements
Module: aes128_enc_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds; only 10 is supported.
REQ-002 SHALL have parameter KIDX_W, default 4, meaning the width of the round-key index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a plaintext block is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept plaintext.
REQ-007 SHALL have port plaintext, input, 128 bits: the block to encrypt, sampled at accept.
REQ-008 SHALL have port key_idx, output, KIDX_W bits: the round-key index requested from the key schedule.
REQ-009 SHALL have port round_key, input, 128 bits: the round key for key_idx, valid combinationally in the same cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: ciphertext is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-012 SHALL have port ciphertext, output, 128 bits: the encrypted block.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, ROUND, FINAL and DONE.
REQ-015 SHALL hold a 128-bit state register and a 4-bit round counter rc.
REQ-016 SHALL drive in_ready=1 only in IDLE.
- Accept = in_valid & in_ready.
REQ-017 On accept, SHALL load state_reg <= plaintext ^ round_key, with key_idx=0, then set rc=1 and go to ROUND.
REQ-018 In ROUND, SHALL drive key_idx=rc and load state_reg <= full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) of state_reg.
- rc increments each cycle.
- When rc=NR-1, the next state is FINAL.
REQ-019 In FINAL, SHALL drive key_idx=NR and load state_reg <= final round (no MixColumns), then go to DONE.
REQ-020 In DONE, SHALL hold out_valid=1 and ciphertext=state_reg stable until out_ready=1, then go to IDLE on that edge.
REQ-021 Latency SHALL be fixed: out_valid rises on the 11th rising edge counting the accept edge as the 1st.
- This is independent of out_ready.
REQ-022 Throughput SHALL be at most one block per 12 cycles.
- There is no overlap: in DONE with out_ready=1, in_ready stays 0 that cycle.
REQ-023 in_valid and plaintext changes while busy SHALL be ignored, with no effect on the block in flight.
REQ-024 out_ready asserted outside DONE SHALL be ignored.
REQ-025 key_idx SHALL be 0 in IDLE and DONE.
- key_idx SHALL never exceed NR.
REQ-026 rc SHALL never wrap.
- Any illegal state encoding SHALL return to IDLE on the next edge.
REQ-027 ciphertext SHALL read 0 whenever out_valid=0.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL go to IDLE, clear state_reg and rc, and drive in_ready=1, out_valid=0, busy=0, key_idx=0 and ciphertext=0 from the next cycle.
- This overrides any accept or handshake in the same cycle.
REQ-029 Reset mid-operation (ROUND, FINAL or DONE) SHALL discard the block with no out_valid pulse.

Configuration
REQ-030 When macro AES_ENC_CTRL_ABORT_EN is defined, the block SHALL add input port abort (1 bit).
- abort=1 at an edge in ROUND, FINAL or DONE returns to IDLE and clears state_reg and rc, with no out_valid.
- abort in IDLE is ignored.
- reset has priority over abort.
REQ-031 Without AES_ENC_CTRL_ABORT_EN, the abort port SHALL be absent and the behaviour SHALL be exactly as in REQ-014..REQ-029.

Structure
REQ-032 Shared package aes_pkg SHALL hold:
- the FSM state enumeration;
- constants AES_NR=10, AES_BLK_W=128 and AES_KIDX_W=4.
REQ-033 The full round SHALL reuse the existing encrypt_round instance.
REQ-034 The final round SHALL be the one new sub-module, aes_final_round (sub_bytes, shift_rows, add_round_key).
REQ-035 The key schedule SHALL be external and indexed by key_idx.

Verification
REQ-036 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid on the 11th edge.
REQ-037 FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32.
- key_idx sequence SHALL be 0,1..10.
REQ-038 Hold out_ready=0 for 5 cycles after out_valid -> ciphertext stable, in_ready=0, busy=1; then out_ready=1 -> IDLE next cycle.
REQ-039 Assert reset at rc=5 -> next cycle IDLE, all outputs at reset values, no out_valid.
- A following C.1 block SHALL still encrypt correctly.
REQ-040 Toggle in_valid and plaintext randomly while busy -> the result SHALL be unchanged from REQ-036.
REQ-041 With AES_ENC_CTRL_ABORT_EN defined: abort in ROUND at rc=3 -> IDLE next cycle, no out_valid; abort and reset together -> reset behaviour.
